qck_gate_sequencer: RTL
=======================

// Module: qck_gate_sequencer
// PURPOSE
//  Initiator side of the QCK gating interface; drives ck_en/qck_mask/skip_req into qck_controller.
//  Accepts per-channel gating commands (ENABLE/GATE/UNGATE/DISABLE) over a valid/ready handshake.
//  Applies a programmable pre-gate delay and checks the controller's ck_out after the pipeline latency.
//  Reports completion and error per channel. Sits between the power-management/CA-QCA scheduler and qck_controller.
// PARAMETERS
//  CHANNELS        8  number of QCK channels
//  PIPELINE_DEPTH  2  qck_controller pipeline depth; confirm latency LAT = PIPELINE_DEPTH+1
//  DELAY_WIDTH     4  width of per-channel pre-gate delay
//  SKIP_CYCLES     4  skip_req pulse length in cycles (>=1)
// PORTS
//  clk          in   1                   core clock, single clock domain
//  reset_n      in   1                   asynchronous active-low reset
//  req_valid    in   1                   command valid
//  req_ready    out  1                   command accepted when req_valid & req_ready
//  req_ch       in   $clog2(CHANNELS)    target channel
//  req_op       in   2                   00 ENABLE, 01 GATE, 10 UNGATE, 11 DISABLE
//  prog_delay   in   CHANNELS*DELAY_WIDTH  pre-gate delay per channel, sampled on GATE acceptance
//  urgent_skip  in   CHANNELS            per-channel skip request pulse
//  ck_out       in   CHANNELS            gated-clock status fed back from qck_controller
//  ck_en        out  CHANNELS            to qck_controller
//  qck_mask     out  CHANNELS            to qck_controller
//  skip_req     out  CHANNELS            to qck_controller
//  done         out  CHANNELS            1-cycle pulse: command on channel completed
//  done_err     out  CHANNELS            valid with done: illegal op or confirm mismatch
//  busy         out  CHANNELS            channel is in a transient state
// BEHAVIOUR
//  Reset: all outputs 0; every channel FSM in OFF; counters 0. Reset mid-operation aborts all commands with no done.
//  All outputs are registered. req_ready is combinational: high iff the FSM for req_ch is in a stable state (OFF/ON/GATED).
//  Per-channel FSM states and (ck_en, qck_mask) values:
//   OFF(0,0)  ON(1,0)  GATED(0,1)  GDLY(1,0)  WAIT_ON  WAIT_OFF  WAIT_GATED (outputs already at target).
//  ENABLE  in OFF    -> ck_en=1 next cycle; WAIT_ON.
//  GATE    in ON     -> GDLY, cnt=prog_delay[ch]; cnt==0 -> (0,1) next cycle; else decrement each cycle, then (0,1); WAIT_GATED.
//  UNGATE  in GATED  -> (1,0) next cycle; WAIT_ON.
//  DISABLE in ON     -> (0,0); WAIT_OFF. DISABLE in GATED -> (0,0); WAIT_OFF.
//  WAIT_x: count LAT cycles after the output change. Sample ck_out[ch] (expected 1 for ON, 0 for OFF/GATED).
//   Then enter the target state and pulse done. done_err=1 on mismatch; the state still advances.
//  Illegal op for the state (e.g. GATE in OFF, ENABLE in ON): accepted; done + done_err pulse next cycle; state unchanged.
//  The GATED encoding (0,1) keeps the controller error (en & mask & ~skip) deasserted in steady state.
//  urgent_skip[ch] in GATED:
//   - skip_req[ch]=1 for SKIP_CYCLES cycles starting next cycle.
//   - A re-pulse during the window restarts the count. FSM state is unchanged.
//   - An UNGATE/DISABLE accepted during the window cancels the skip in the same cycle the outputs change.
//  urgent_skip in any other state is ignored; skip_req stays 0.
//  Channels are independent: simultaneous completions on several channels pulse done in the same cycle.
//  Only one new command is accepted per cycle.
//  Delay counter saturates at 0. prog_delay changes after acceptance do not affect an active GDLY.
// STRUCTURE
//  Package qck_pkg: qck_op_e (ENABLE/GATE/UNGATE/DISABLE), qck_chan_state_e, localparam LAT helper.
//  Sub-module qck_chan_fsm: one channel (FSM, delay counter, latency counter, skip counter).
//   Generate-instantiated CHANNELS times. Top level decodes req_ch to a per-channel accept strobe and muxes req_ready.
// TESTING
//  Reset, then ENABLE ch3 with ck_out[3] rising at LAT=3 -> ck_en[3]=1 after 1 cycle; done[3] 4 cycles after accept; done_err[3]=0.
//  ch3 ON, prog_delay[3]=5, GATE -> mask stays 0 for 5 cycles, then ck_en=0/mask=1; done[3] LAT later.
//  ch0 GATED, urgent_skip[0] pulse -> skip_req[0]=1 for exactly 4 cycles; state GATED; no done.
//  GATE on ch5 in OFF -> req_ready=1; done[5]=done_err[5]=1 next cycle; outputs unchanged.
//  ENABLE ch1 with ck_out[1] held 0 -> done[1]=1 and done_err[1]=1 at LAT; state ON.
//  ch2 in GDLY with cnt=7, reset_n low -> all outputs 0 asynchronously; after release ENABLE ch2 accepted normally.

Source files
------------

// File: rtl/qck_pkg.sv
// Shared types and helpers for the QCK gate sequencer: command opcodes,
// per-channel FSM states and the confirm-latency helper.
package qck_pkg;

  typedef enum logic [1:0] {
    OP_ENABLE  = 2'b00,
    OP_GATE    = 2'b01,
    OP_UNGATE  = 2'b10,
    OP_DISABLE = 2'b11
  } qck_op_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ON,
    ST_GATED,
    ST_GDLY,
    ST_WAIT_ON,
    ST_WAIT_OFF,
    ST_WAIT_GATED
  } qck_chan_state_e;

  // ck_out reflects a ck_en/qck_mask change one cycle after the controller pipeline
  function automatic int qck_lat(input int pipeline_depth);
    return pipeline_depth + 1;
  endfunction

  function automatic logic qck_is_stable(input qck_chan_state_e s);
    return (s == ST_OFF) || (s == ST_ON) || (s == ST_GATED);
  endfunction

endpackage

// File: rtl/qck_chan_fsm.sv
// One QCK channel: command FSM, pre-gate delay counter, confirm latency
// counter and urgent-skip pulse stretcher.
module qck_chan_fsm
  import qck_pkg::*;
#(
  parameter int PIPELINE_DEPTH = 2,
  parameter int DELAY_WIDTH    = 4,
  parameter int SKIP_CYCLES    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   accept_i,
  input  logic [1:0]             op_i,
  input  logic [DELAY_WIDTH-1:0] delay_i,
  input  logic                   skip_i,
  input  logic                   ck_out_i,
  output logic                   stable_o,
  output logic                   ck_en_o,
  output logic                   mask_o,
  output logic                   skip_req_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int LAT    = qck_lat(PIPELINE_DEPTH);
  localparam int LAT_W  = $clog2(LAT + 1);
  localparam int SKIP_W = $clog2(SKIP_CYCLES + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LAT - 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_CYCLES - 1);

  qck_chan_state_e        state_q, state_d;
  logic                   ck_en_q, ck_en_d;
  logic                   mask_q, mask_d;
  logic                   skip_q, skip_d;
  logic [SKIP_W-1:0]      skip_cnt_q, skip_cnt_d;
  logic [DELAY_WIDTH-1:0] dly_q, dly_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      ck_en_q    <= 1'b0;
      mask_q     <= 1'b0;
      skip_q     <= 1'b0;
      skip_cnt_q <= '0;
      dly_q      <= '0;
      lat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ck_en_q    <= ck_en_d;
      mask_q     <= mask_d;
      skip_q     <= skip_d;
      skip_cnt_q <= skip_cnt_d;
      dly_q      <= dly_d;
      lat_q      <= lat_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ck_en_d    = ck_en_q;
    mask_d     = mask_q;
    skip_d     = skip_q;
    skip_cnt_d = skip_cnt_q;
    dly_d      = dly_q;
    lat_d      = lat_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    legal      = 1'b0;

    if (skip_q) begin
      if (skip_cnt_q == '0) skip_d = 1'b0;
      else                  skip_cnt_d = skip_cnt_q - 1'b1;
    end
    // A fresh pulse while gated (re)starts the window
    if (state_q == ST_GATED && skip_i) begin
      skip_d     = 1'b1;
      skip_cnt_d = SKIP_LOAD;
    end

    case (state_q)
      ST_OFF, ST_ON, ST_GATED: begin
        if (accept_i) begin
          if (op_i == OP_ENABLE && state_q == ST_OFF) begin
            legal   = 1'b1;
            ck_en_d = 1'b1;
            mask_d  = 1'b0;
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT_ON;
          end else if (op_i == OP_GATE && state_q == ST_ON) begin
            legal = 1'b1;
            if (delay_i == '0) begin
              ck_en_d = 1'b0;
              mask_d  = 1'b1;
              lat_d   = LAT_LOAD;
              state_d = ST_WAIT_GATED;
            end else begin
              dly_d   = delay_i;
              state_d = ST_GDLY;
            end
          end else if (op_i == OP_UNGATE && state_q == ST_GATED) begin
            legal   = 1'b1;
            ck_en_d = 1'b1;
            mask_d  = 1'b0;
            skip_d  = 1'b0;
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT_ON;
          end else if (op_i == OP_DISABLE && state_q != ST_OFF) begin
            legal   = 1'b1;
            ck_en_d = 1'b0;
            mask_d  = 1'b0;
            skip_d  = 1'b0;
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT_OFF;
          end
          done_d = !legal;
          err_d  = !legal;
        end
      end
      ST_GDLY: begin
        // dly_q counts the remaining cycles with the clock still running
        if (dly_q <= DELAY_WIDTH'(1)) begin
          dly_d   = '0;
          ck_en_d = 1'b0;
          mask_d  = 1'b1;
          lat_d   = LAT_LOAD;
          state_d = ST_WAIT_GATED;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_WAIT_ON, ST_WAIT_OFF, ST_WAIT_GATED: begin
        if (lat_q == '0) begin
          done_d = 1'b1;
          if (state_q == ST_WAIT_ON) begin
            err_d   = !ck_out_i;
            state_d = ST_ON;
          end else if (state_q == ST_WAIT_OFF) begin
            err_d   = ck_out_i;
            state_d = ST_OFF;
          end else begin
            err_d   = ck_out_i;
            state_d = ST_GATED;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    busy_d = !qck_is_stable(state_d);
  end

  always_comb begin
    stable_o   = qck_is_stable(state_q);
    ck_en_o    = ck_en_q;
    mask_o     = mask_q;
    skip_req_o = skip_q;
    done_o     = done_q;
    err_o      = err_q;
    busy_o     = busy_q;
  end

endmodule

// File: rtl/qck_gate_sequencer.sv
// QCK gating initiator: routes one command per cycle to the addressed channel
// FSM and collects per-channel controls and completion status.
module qck_gate_sequencer
  import qck_pkg::*;
#(
  parameter int CHANNELS       = 8,
  parameter int PIPELINE_DEPTH = 2,
  parameter int DELAY_WIDTH    = 4,
  parameter int SKIP_CYCLES    = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [$clog2(CHANNELS)-1:0]     req_ch,
  input  logic [1:0]                      req_op,
  input  logic [CHANNELS*DELAY_WIDTH-1:0] prog_delay,
  input  logic [CHANNELS-1:0]             urgent_skip,
  input  logic [CHANNELS-1:0]             ck_out,
  output logic [CHANNELS-1:0]             ck_en,
  output logic [CHANNELS-1:0]             qck_mask,
  output logic [CHANNELS-1:0]             skip_req,
  output logic [CHANNELS-1:0]             done,
  output logic [CHANNELS-1:0]             done_err,
  output logic [CHANNELS-1:0]             busy
);

  localparam int CH_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0] stable;
  logic                accept;

  assign req_ready = stable[req_ch];
  assign accept    = req_valid && req_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    qck_chan_fsm #(
      .PIPELINE_DEPTH(PIPELINE_DEPTH),
      .DELAY_WIDTH   (DELAY_WIDTH),
      .SKIP_CYCLES   (SKIP_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .accept_i   (accept && (req_ch == CH_W'(g))),
      .op_i       (req_op),
      .delay_i    (prog_delay[g*DELAY_WIDTH +: DELAY_WIDTH]),
      .skip_i     (urgent_skip[g]),
      .ck_out_i   (ck_out[g]),
      .stable_o   (stable[g]),
      .ck_en_o    (ck_en[g]),
      .mask_o     (qck_mask[g]),
      .skip_req_o (skip_req[g]),
      .done_o     (done[g]),
      .err_o      (done_err[g]),
      .busy_o     (busy[g])
    );
  end

endmodule
